sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-requester arbiter and strobe sequencer for the 64K x 8 asynchronous system SRAM, which has active-low CS/WE/OE, a 16-bit address and an 8-bit bidirectional data bus.
- Port 0 is the CPU bus; port 1 is the DMA/host loader that preloads program images.
- The block grants the SRAM round-robin and generates setup, strobe and hold phases with programmable wait states.
- The tri-state data pin is built at top level from ram_dout/ram_dout_en.

Parameters:
WAIT_STATES, 1, extra strobe cycles beyond the first (range 0..7)
ADDR_W, 16, address width
DATA_W, 8, data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req0  in  1  port 0 request; hold high until done0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 owns the current transaction (SETUP..HOLD)
done0  out  1  one-cycle completion pulse for port 0
req1, we1, addr1, wdata1, gnt1, done1: same as port 0, for port 1
rdata  out  DATA_W  read data, valid in the done cycle, held until the next read completes
ram_addr  out  ADDR_W  SRAM address
ram_dout  out  DATA_W  SRAM write data
ram_dout_en  out  1  drive data pin
ram_din  in  DATA_W  SRAM data pin sampled
ram_cs_n, ram_we_n, ram_oe_n  out  1  SRAM strobes, active low

Behaviour:
- Reset values: ram_cs_n=ram_we_n=ram_oe_n=1, ram_dout_en=0, ram_addr=0, ram_dout=0, rdata=0, gnt*=0, done*=0, last-grant pointer=1 (so port 0 wins the first tie). FSM=IDLE.
- All outputs are registered. Strobes never glitch.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - All strobes high, ram_dout_en=0.
  - If any req is high, pick the winner: a single requester wins outright; if both request, the port not granted last wins.
  - Latch the winner's we, addr and wdata into ram_addr, ram_dout and the op register. Go to SETUP.
- SETUP (1 cycle):
  - gnt set and ram_cs_n=0.
  - Write: ram_dout_en=1, ram_we_n=1.
  - Read: ram_oe_n=0.
- STROBE (WAIT_STATES+1 cycles, via a down-counter loaded on SETUP entry):
  - Write: ram_we_n=0.
  - Read: ram_oe_n=0. On the final STROBE cycle, rdata <= ram_din.
- HOLD (1 cycle):
  - ram_we_n=1, ram_oe_n=1, ram_cs_n=0.
  - Write: ram_dout_en stays 1 to give data hold.
  - done pulses for the owner. rdata is valid for a read.
  - Update the last-grant pointer. Go to IDLE. gnt clears on the IDLE entry edge.
- Transaction length from grant edge to done: 2+WAIT_STATES+1 cycles. Minimum request spacing: 4+WAIT_STATES cycles, because IDLE always separates transactions.
- Request fields are sampled only in IDLE. Changes mid-transaction are ignored.
- A requester dropping req mid-transaction has no effect: the access completes and done still pulses.
- The non-owner's req stays pending. Round-robin guarantees service within one transaction.
- Invariant: ram_we_n and ram_oe_n are never both 0. ram_dout_en=1 implies ram_oe_n=1. Both are checked with assertions.
- Reset asserted mid-operation: on the next edge all strobes go high, ram_dout_en=0, FSM=IDLE, no done pulse. The aborted write may be partial; this is accepted.
- Writes do not update rdata.

Decomposition:
- sram_arb_pkg holds:
  - typedef enum state_t {IDLE, SETUP, STROBE, HOLD}
  - typedef struct mem_req_t {we, addr, wdata}
  - localparam NUM_PORTS=2
- Sub-module rr_arb2: two-input round-robin picker with a registered last-grant pointer and an update strobe. It is combinational grant plus one flop, reused elsewhere.
- The FSM, wait counter and output registers stay in sram_arbiter.

Test Plan:
1. Single read, WAIT_STATES=1. SRAM model holds 0xA5 at 0x1234; req0=1, we0=0, addr0=0x1234.
   - ram_oe_n low for 3 cycles (SETUP + 2 STROBE).
   - done0 pulses 4 cycles after grant with rdata=0xA5.
   - ram_we_n stays 1 throughout.
2. Single write. req1, we1=1, addr1=0x0100, wdata1=0x3C.
   - ram_we_n low for exactly 2 cycles.
   - ram_dout_en high from SETUP through HOLD.
   - A subsequent port-0 read of 0x0100 returns 0x3C.
3. Contention. req0 and req1 both high from reset, each for 3 transactions.
   - Grants alternate 0,1,0,1,0,1.
   - Every done is matched to its own port.
   - A single-port stream gets consecutive grants.
4. Wait-state sweep. WAIT_STATES=0 and WAIT_STATES=7.
   - Strobe widths are 1 and 8 cycles.
   - Back-to-back transaction spacing is 4 and 11 cycles.
5. Reset in STROBE of a write.
   - Next edge: all strobes=1, ram_dout_en=0, no done.
   - A fresh request is served normally afterward.
6. Request fields change and req0 drops mid-read.
   - ram_addr stays at the IDLE-sampled value.
   - done0 still pulses.
   - The WE/OE-overlap assertion never fires.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational grant, one flop of history.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 upd,
  input  logic                 upd_idx,
  output logic [NUM_PORTS-1:0] gnt_c
);

  logic last_q;

  // Lone requester wins outright; on a tie the port not granted last wins
  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = last_q ? 2'b01 : 2'b10;
    end
  end

  // Last-grant pointer; starts at 1 so port 0 takes the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_idx;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for a 64K x 8 asynchronous SRAM.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_dout_en,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic              ram_oe_n
);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  owner_q, owner_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d, done_q, done_d, arb_gnt_c;
  logic [ADDR_W-1:0]     addr_d;
  logic [DATA_W-1:0]     dout_d, rdata_d;
  logic                  cs_n_d, we_n_d, oe_n_d, dout_en_d, arb_upd;
  mem_req_t              sel_c;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .upd     (arb_upd),
    .upd_idx (owner_q),
    .gnt_c   (arb_gnt_c)
  );

  // Request fields of the port the picker currently favours
  always_comb begin
    if (arb_gnt_c[1]) begin
      sel_c = '{we: we1, addr: MEM_ADDR_W'(addr1), wdata: MEM_DATA_W'(wdata1)};
    end else begin
      sel_c = '{we: we0, addr: MEM_ADDR_W'(addr0), wdata: MEM_DATA_W'(wdata0)};
    end
  end

  // Next state plus next value of every output flop; strobes default inactive
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    addr_d    = ram_addr;
    dout_d    = ram_dout;
    rdata_d   = rdata;
    done_d    = '0;
    cs_n_d    = 1'b1;
    we_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    dout_en_d = 1'b0;
    arb_upd   = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|arb_gnt_c) begin
          state_d   = SETUP;
          owner_d   = arb_gnt_c[1];
          gnt_d     = arb_gnt_c;
          we_d      = sel_c.we;
          addr_d    = ADDR_W'(sel_c.addr);
          dout_d    = DATA_W'(sel_c.wdata);
          cnt_d     = WAIT_CNT_W'(WAIT_STATES);
          cs_n_d    = 1'b0;
          dout_en_d = sel_c.we;
          oe_n_d    = sel_c.we;
        end
      end
      SETUP: begin
        state_d   = STROBE;
        cs_n_d    = 1'b0;
        dout_en_d = we_q;
        we_n_d    = !we_q;
        oe_n_d    = we_q;
      end
      STROBE: begin
        cs_n_d    = 1'b0;
        dout_en_d = we_q;
        if (cnt_q == '0) begin
          // Last strobe cycle: release strobes, capture read data, flag completion
          state_d = HOLD;
          done_d  = gnt_q;
          if (!we_q) begin
            rdata_d = ram_din;
          end
        end else begin
          cnt_d  = cnt_q - WAIT_CNT_W'(1);
          we_n_d = !we_q;
          oe_n_d = we_q;
        end
      end
      HOLD: begin
        state_d = IDLE;
        gnt_d   = '0;
        arb_upd = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      ram_addr    <= '0;
      ram_dout    <= '0;
      rdata       <= '0;
      ram_cs_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_dout_en <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      ram_addr    <= addr_d;
      ram_dout    <= dout_d;
      rdata       <= rdata_d;
      ram_cs_n    <= cs_n_d;
      ram_we_n    <= we_n_d;
      ram_oe_n    <= oe_n_d;
      ram_dout_en <= dout_en_d;
    end
  end

  assign gnt0  = gnt_q[0];
  assign gnt1  = gnt_q[1];
  assign done0 = done_q[0];
  assign done1 = done_q[1];

  // Never read and write at once; never drive the pin while the SRAM drives it
  assert property (@(posedge clk) disable iff (reset) !(!ram_we_n && !ram_oe_n));
  assert property (@(posedge clk) disable iff (reset) ram_dout_en |-> ram_oe_n);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter; instances 0/1/2 run WAIT_STATES 1/0/7.
module tb_sram_arbiter;

  localparam int unsigned NI = 3;

  logic clk = 1'b0;
  logic reset;
  logic req0 [NI], we0 [NI], req1 [NI], we1 [NI];
  logic [15:0] addr0 [NI], addr1 [NI], ram_addr [NI];
  logic [7:0] wdata0 [NI], wdata1 [NI], rdata [NI], ram_dout [NI], ram_din [NI];
  logic gnt0 [NI], gnt1 [NI], done0 [NI], done1 [NI];
  logic ram_dout_en [NI], ram_cs_n [NI], ram_we_n [NI], ram_oe_n [NI];

  logic [7:0] mem [65536];
  bit         wvalid [65536];

  int n_checks = 0;
  int n_fail   = 0;
  int inv_bad  = 0;
  int k        = 0;

  int t_oe, t_we, t_den, t_gnt, t_done_at, t_done_p;
  logic [7:0] t_rd;
  int s_order [8], s_gt [8], s_dp [8];
  logic [7:0] s_rv [8];
  int s_ng, s_nd;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_arbiter #(
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 7)),
      .ADDR_W(16),
      .DATA_W(8)
    ) dut (
      .clk(clk), .reset(reset),
      .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
      .gnt0(gnt0[g]), .done0(done0[g]),
      .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
      .gnt1(gnt1[g]), .done1(done1[g]),
      .rdata(rdata[g]), .ram_addr(ram_addr[g]), .ram_dout(ram_dout[g]),
      .ram_dout_en(ram_dout_en[g]), .ram_din(ram_din[g]),
      .ram_cs_n(ram_cs_n[g]), .ram_we_n(ram_we_n[g]), .ram_oe_n(ram_oe_n[g])
    );
    assign ram_din[g] = (!ram_cs_n[g] && !ram_oe_n[g]) ?
                        (wvalid[ram_addr[g]] ? mem[ram_addr[g]] : init_val(ram_addr[g])) : 8'h00;
  end

  // Power-up SRAM contents for locations never written
  function automatic logic [7:0] init_val(input logic [15:0] a);
    case (a)
      16'h1234: return 8'hA5;
      16'h0010: return 8'h11;
      16'h0020: return 8'h22;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // SRAM write model, shared by all instances
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!ram_cs_n[i] && !ram_we_n[i] && ram_dout_en[i]) begin
        mem[ram_addr[i]]    = ram_dout[i];
        wvalid[ram_addr[i]] = 1'b1;
      end
    end
  end

  // Strobe invariant monitor
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!ram_we_n[i] && !ram_oe_n[i]) inv_bad++;
      if (ram_dout_en[i] && !ram_oe_n[i]) inv_bad++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic r, input logic we,
                         input logic [15:0] a, input logic [7:0] d);
    if (p == 0) begin
      req0[k] = r; we0[k] = we; addr0[k] = a; wdata0[k] = d;
    end else begin
      req1[k] = r; we1[k] = we; addr1[k] = a; wdata1[k] = d;
    end
  endtask

  // One transaction on port p of instance k; records strobe widths and done timing
  task automatic do_txn(input int p, input logic we, input logic [15:0] a, input logic [7:0] d);
    t_oe = 0; t_we = 0; t_den = 0; t_gnt = 0; t_done_at = -1; t_done_p = -1; t_rd = 8'h00;
    set_req(p, 1'b1, we, a, d);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!ram_oe_n[k]) t_oe++;
      if (!ram_we_n[k]) t_we++;
      if (ram_dout_en[k]) t_den++;
      if ((p == 0) ? gnt0[k] : gnt1[k]) t_gnt++;
      if (done0[k] || done1[k]) begin
        t_done_at = t_gnt;
        t_done_p  = done1[k] ? 1 : 0;
        t_rd      = rdata[k];
        break;
      end
    end
    set_req(p, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  // Reads on the enabled ports, n each; records grant order/time and done port/data
  task automatic run_stream(input bit use0, input bit use1, input int n);
    int c0, c1, total;
    logic p0, p1;
    c0 = 0; c1 = 0; p0 = 1'b0; p1 = 1'b0; s_ng = 0; s_nd = 0;
    total = (use0 ? n : 0) + (use1 ? n : 0);
    for (int i = 0; i < 8; i++) begin
      s_order[i] = -1; s_gt[i] = -1; s_dp[i] = -1; s_rv[i] = 8'h00;
    end
    if (use0) set_req(0, 1'b1, 1'b0, 16'h0010, 8'h00);
    if (use1) set_req(1, 1'b1, 1'b0, 16'h0020, 8'h00);
    reset = 1'b0;
    for (int cyc = 0; cyc < 300 && s_nd < total; cyc++) begin
      tick();
      if (gnt0[k] && !p0) begin
        if (s_ng < 8) begin s_order[s_ng] = 0; s_gt[s_ng] = cyc; end
        s_ng++;
      end
      if (gnt1[k] && !p1) begin
        if (s_ng < 8) begin s_order[s_ng] = 1; s_gt[s_ng] = cyc; end
        s_ng++;
      end
      p0 = gnt0[k];
      p1 = gnt1[k];
      if (done0[k]) begin
        if (s_nd < 8) begin s_dp[s_nd] = 0; s_rv[s_nd] = rdata[k]; end
        s_nd++; c0++;
        if (c0 == n) req0[k] = 1'b0;
      end
      if (done1[k]) begin
        if (s_nd < 8) begin s_dp[s_nd] = 1; s_rv[s_nd] = rdata[k]; end
        s_nd++; c1++;
        if (c1 == n) req1[k] = 1'b0;
      end
    end
    req0[k] = 1'b0;
    req1[k] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = 16'h0; wdata0[i] = 8'h0;
      req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = 16'h0; wdata1[i] = 8'h0;
    end
    tick(); tick();
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if ({ram_cs_n[i], ram_we_n[i], ram_oe_n[i], ram_dout_en[i], gnt0[i], gnt1[i], done0[i], done1[i]} !== 8'b1110_0000) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 11100000", i,
                 {ram_cs_n[i], ram_we_n[i], ram_oe_n[i], ram_dout_en[i], gnt0[i], gnt1[i], done0[i], done1[i]});
      end
      n_checks++;
      if (ram_addr[i] !== 16'h0000) begin n_fail++; $display("FAIL reset_addr[%0d]: got %h expected 0000", i, ram_addr[i]); end
      n_checks++;
      if (ram_dout[i] !== 8'h00) begin n_fail++; $display("FAIL reset_dout[%0d]: got %h expected 00", i, ram_dout[i]); end
      n_checks++;
      if (rdata[i] !== 8'h00) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 00", i, rdata[i]); end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    k = 0;
    do_txn(0, 1'b0, 16'h1234, 8'h00);
    n_checks++;
    if (t_oe !== 3) begin n_fail++; $display("FAIL read_oe_width: got %0d expected 3", t_oe); end
    n_checks++;
    if (t_we !== 0) begin n_fail++; $display("FAIL read_we_low: got %0d expected 0", t_we); end
    n_checks++;
    if (t_den !== 0) begin n_fail++; $display("FAIL read_dout_en: got %0d expected 0", t_den); end
    n_checks++;
    if (t_done_at !== 4) begin n_fail++; $display("FAIL read_done_cycle: got %0d expected 4", t_done_at); end
    n_checks++;
    if (t_done_p !== 0) begin n_fail++; $display("FAIL read_done_port: got %0d expected 0", t_done_p); end
    n_checks++;
    if (t_rd !== 8'hA5) begin n_fail++; $display("FAIL read_rdata: got %h expected a5", t_rd); end
    tick();
    n_checks++;
    if ({done0[k], gnt0[k], ram_cs_n[k]} !== 3'b001) begin
      n_fail++; $display("FAIL read_after_hold: got %b expected 001", {done0[k], gnt0[k], ram_cs_n[k]});
    end
    n_checks++;
    if (rdata[k] !== 8'hA5) begin n_fail++; $display("FAIL read_rdata_held: got %h expected a5", rdata[k]); end
  endtask

  task automatic test_single_write();
    k = 0;
    do_txn(1, 1'b1, 16'h0100, 8'h3C);
    n_checks++;
    if (t_we !== 2) begin n_fail++; $display("FAIL write_we_width: got %0d expected 2", t_we); end
    n_checks++;
    if (t_den !== 4) begin n_fail++; $display("FAIL write_dout_en_width: got %0d expected 4", t_den); end
    n_checks++;
    if (t_oe !== 0) begin n_fail++; $display("FAIL write_oe_low: got %0d expected 0", t_oe); end
    n_checks++;
    if (t_done_p !== 1) begin n_fail++; $display("FAIL write_done_port: got %0d expected 1", t_done_p); end
    n_checks++;
    if (t_rd !== 8'hA5) begin n_fail++; $display("FAIL write_keeps_rdata: got %h expected a5", t_rd); end
    tick();
    do_txn(0, 1'b0, 16'h0100, 8'h00);
    n_checks++;
    if (t_rd !== 8'h3C) begin n_fail++; $display("FAIL write_readback: got %h expected 3c", t_rd); end
    tick();
  endtask

  task automatic test_contention();
    k = 0;
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0010, 8'h00);
    set_req(1, 1'b1, 1'b0, 16'h0020, 8'h00);
    tick(); tick();
    run_stream(1'b1, 1'b1, 3);
    n_checks++;
    if (s_nd !== 6) begin n_fail++; $display("FAIL cont_done_count: got %0d expected 6", s_nd); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (s_order[i] !== i % 2) begin n_fail++; $display("FAIL cont_grant[%0d]: got %0d expected %0d", i, s_order[i], i % 2); end
      n_checks++;
      if (s_dp[i] !== i % 2) begin n_fail++; $display("FAIL cont_done_port[%0d]: got %0d expected %0d", i, s_dp[i], i % 2); end
      n_checks++;
      if (s_rv[i] !== ((i % 2 == 0) ? 8'h11 : 8'h22)) begin
        n_fail++; $display("FAIL cont_rdata[%0d]: got %h expected %h", i, s_rv[i], (i % 2 == 0) ? 8'h11 : 8'h22);
      end
    end
    for (int i = 1; i < 6; i++) begin
      n_checks++;
      if (s_gt[i] - s_gt[i-1] !== 5) begin n_fail++; $display("FAIL cont_spacing[%0d]: got %0d expected 5", i, s_gt[i] - s_gt[i-1]); end
    end
    run_stream(1'b0, 1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (s_order[i] !== 1 || s_dp[i] !== 1) begin
        n_fail++; $display("FAIL solo_grant[%0d]: got grant %0d done %0d expected 1 1", i, s_order[i], s_dp[i]);
      end
    end
    n_checks++;
    if (s_gt[2] - s_gt[1] !== 5) begin n_fail++; $display("FAIL solo_spacing: got %0d expected 5", s_gt[2] - s_gt[1]); end
  endtask

  task automatic test_wait_sweep();
    int ws;
    for (int inst = 1; inst <= 2; inst++) begin
      k  = inst;
      ws = (inst == 1) ? 0 : 7;
      do_txn(0, 1'b1, 16'h0300, 8'h4B);
      n_checks++;
      if (t_we !== ws + 1) begin n_fail++; $display("FAIL ws%0d_we_width: got %0d expected %0d", ws, t_we, ws + 1); end
      n_checks++;
      if (t_den !== ws + 3) begin n_fail++; $display("FAIL ws%0d_dout_en: got %0d expected %0d", ws, t_den, ws + 3); end
      n_checks++;
      if (t_done_at !== ws + 3) begin n_fail++; $display("FAIL ws%0d_done_cycle: got %0d expected %0d", ws, t_done_at, ws + 3); end
      tick();
      do_txn(1, 1'b0, 16'h0300, 8'h00);
      n_checks++;
      if (t_oe !== ws + 2) begin n_fail++; $display("FAIL ws%0d_oe_width: got %0d expected %0d", ws, t_oe, ws + 2); end
      n_checks++;
      if (t_rd !== 8'h4B) begin n_fail++; $display("FAIL ws%0d_readback: got %h expected 4b", ws, t_rd); end
      tick();
      run_stream(1'b1, 1'b0, 2);
      n_checks++;
      if (s_gt[1] - s_gt[0] !== ws + 4) begin
        n_fail++; $display("FAIL ws%0d_spacing: got %0d expected %0d", ws, s_gt[1] - s_gt[0], ws + 4);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen, bad_done;
    k = 0; seen = 1'b0; bad_done = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'h0200, 8'h77);
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (!ram_we_n[k]) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_mid_reach_strobe: got 0 expected 1"); end
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    n_checks++;
    if ({ram_cs_n[k], ram_we_n[k], ram_oe_n[k], ram_dout_en[k], done0[k], gnt0[k]} !== 6'b111000) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b expected 111000",
                         {ram_cs_n[k], ram_we_n[k], ram_oe_n[k], ram_dout_en[k], done0[k], gnt0[k]});
    end
    n_checks++;
    if (rdata[k] !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected 00", rdata[k]); end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done0[k] || done1[k] || !ram_cs_n[k]) bad_done = 1'b1;
    end
    n_checks++;
    if (bad_done) begin n_fail++; $display("FAIL rst_mid_quiet: got activity expected none"); end
    do_txn(0, 1'b0, 16'h1234, 8'h00);
    n_checks++;
    if (t_done_at !== 4 || t_rd !== 8'hA5) begin
      n_fail++; $display("FAIL rst_mid_fresh_read: got done %0d data %h expected 4 a5", t_done_at, t_rd);
    end
    tick();
  endtask

  task automatic test_field_change();
    int bad_addr, bad_we;
    bit got_gnt, got_done;
    logic [7:0] rd;
    k = 0; bad_addr = 0; bad_we = 0; got_gnt = 1'b0; got_done = 1'b0; rd = 8'h00;
    set_req(0, 1'b1, 1'b0, 16'h1234, 8'h00);
    for (int c = 0; c < 5 && !got_gnt; c++) begin
      tick();
      if (gnt0[k]) got_gnt = 1'b1;
    end
    set_req(0, 1'b0, 1'b1, 16'hBEEF, 8'hFF);
    for (int c = 0; c < 10 && !got_done; c++) begin
      tick();
      if (ram_addr[k] !== 16'h1234) bad_addr++;
      if (!ram_we_n[k]) bad_we++;
      if (done0[k]) begin got_done = 1'b1; rd = rdata[k]; end
    end
    n_checks++;
    if (!got_gnt || !got_done) begin n_fail++; $display("FAIL chg_done: got gnt %0b done %0b expected 1 1", got_gnt, got_done); end
    n_checks++;
    if (bad_addr !== 0) begin n_fail++; $display("FAIL chg_addr_stable: got %0d bad cycles expected 0", bad_addr); end
    n_checks++;
    if (bad_we !== 0) begin n_fail++; $display("FAIL chg_no_write: got %0d we cycles expected 0", bad_we); end
    n_checks++;
    if (rd !== 8'hA5) begin n_fail++; $display("FAIL chg_rdata: got %h expected a5", rd); end
    n_checks++;
    if (wvalid[16'hBEEF] !== 1'b0) begin n_fail++; $display("FAIL chg_mem_untouched: got 1 expected 0"); end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_wait_sweep();
    test_reset_mid_write();
    test_field_change();
    n_checks++;
    if (inv_bad !== 0) begin n_fail++; $display("FAIL strobe_invariant: got %0d violations expected 0", inv_bad); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
